// File: rtl/branch_predictor_pkg.sv
// Shared predictor types: BTB entry layout, 2-bit BHT counter encoding and
// its saturating update.
package riscv_defines;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_SNT   = 2'b00;
    localparam bht_ctr_t BHT_WNT   = 2'b01;
    localparam bht_ctr_t BHT_WT    = 2'b10;
    localparam bht_ctr_t BHT_STT   = 2'b11;
    localparam bht_ctr_t BHT_RESET = BHT_WNT;

    // Tag field is sized for a zero-bit index; smaller tags are zero-extended.
    localparam int BTB_TAG_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic                 is_branch;
    } btb_entry_t;

    function automatic bht_ctr_t bht_next(input bht_ctr_t c, input logic taken);
        if (taken) return (c == BHT_STT) ? c : c + 2'd1;
        else       return (c == BHT_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and resolution-update signals between the pipeline (master)
// and the branch predictor (slave).
interface branch_predictor_if #(
    parameter int BHT_IDX_BITS = 8
);
    logic [31:0]             pc_fetch;
    logic                    fetch_valid;
    logic                    pred_taken;
    logic [31:0]             pc_pred;
    logic [BHT_IDX_BITS-1:0] pred_ghr;
    logic                    upd_valid;
    logic                    upd_is_branch;
    logic [31:0]             upd_pc;
    logic                    upd_taken;
    logic [31:0]             upd_target;
    logic                    upd_mispredict;
    logic [BHT_IDX_BITS-1:0] upd_ghr;

    modport master (
        output pc_fetch, fetch_valid, upd_valid, upd_is_branch, upd_pc,
               upd_taken, upd_target, upd_mispredict, upd_ghr,
        input  pred_taken, pc_pred, pred_ghr
    );

    modport slave (
        input  pc_fetch, fetch_valid, upd_valid, upd_is_branch, upd_pc,
               upd_taken, upd_target, upd_mispredict, upd_ghr,
        output pred_taken, pc_pred, pred_ghr
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB: combinational read with tag compare, one write port.
// Addresses are word addresses (pc[31:2]).
module btb_array
    import riscv_defines::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] i_rd_pcw,
    output logic        o_hit,
    output logic [31:0] o_target,
    output logic        o_is_branch,
    input  logic        i_we,
    input  logic [29:0] i_wr_pcw,
    input  logic [31:0] i_wr_target,
    input  logic        i_wr_is_branch
);
    localparam int N = 1 << IDX_BITS;

    btb_entry_t           r_mem [N];
    btb_entry_t           w_rd;
    logic [BTB_TAG_W-1:0] w_rd_tag, w_wr_tag;

    assign w_rd_tag = BTB_TAG_W'(i_rd_pcw[29:IDX_BITS]);
    assign w_wr_tag = BTB_TAG_W'(i_wr_pcw[29:IDX_BITS]);
    assign w_rd     = r_mem[i_rd_pcw[IDX_BITS-1:0]];

    assign o_hit       = w_rd.valid && (w_rd.tag == w_rd_tag);
    assign o_target    = w_rd.target;
    assign o_is_branch = w_rd.is_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_wr_pcw[IDX_BITS-1:0]] <= '{valid: 1'b1, tag: w_wr_tag,
                                               target: i_wr_target,
                                               is_branch: i_wr_is_branch};
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: BTB + 2-bit BHT lookup in the fetch cycle, training
// from a registered resolution update. BPU_GSHARE_EN enables GHR/gshare indexing.
module branch_predictor
    import riscv_defines::*;
#(
    parameter int BTB_IDX_BITS = 6,
    parameter int BHT_IDX_BITS = 8
) (
    input logic               clk,
    input logic               start,
    branch_predictor_if.slave bp
);
    localparam int BHT_N = 1 << BHT_IDX_BITS;

    logic                    r_upd_vld, r_upd_br, r_upd_taken;
    logic [29:0]             r_upd_pcw;
    logic [31:0]             r_upd_tgt;
    logic [BHT_IDX_BITS-1:0] r_upd_idx;
    bht_ctr_t                r_bht [BHT_N];

    logic                    w_hit, w_is_br, w_ctr_t, w_pred;
    logic [31:0]             w_tgt;
    logic [BHT_IDX_BITS-1:0] w_lk_idx, w_upd_idx, w_ghr;
    logic                    w_unused;

`ifdef BPU_GSHARE_EN
    logic [BHT_IDX_BITS-1:0] r_ghr;

    assign w_ghr     = r_ghr;
    assign w_lk_idx  = bp.pc_fetch[BHT_IDX_BITS+1:2] ^ r_ghr;
    assign w_upd_idx = bp.upd_pc[BHT_IDX_BITS+1:2] ^ bp.upd_ghr;
    assign w_unused  = ^bp.upd_pc[1:0];

    // Repair from a mispredicted branch beats the speculative shift.
    always_ff @(posedge clk or negedge start) begin
        if (!start)
            r_ghr <= '0;
        else if (bp.upd_valid && bp.upd_mispredict && bp.upd_is_branch)
            r_ghr <= {bp.upd_ghr[BHT_IDX_BITS-2:0], bp.upd_taken};
        else if (bp.fetch_valid && w_hit && w_is_br)
            r_ghr <= {r_ghr[BHT_IDX_BITS-2:0], w_pred};
    end
`else
    assign w_ghr     = '0;
    assign w_lk_idx  = bp.pc_fetch[BHT_IDX_BITS+1:2];
    assign w_upd_idx = bp.upd_pc[BHT_IDX_BITS+1:2];
    assign w_unused  = ^{bp.upd_pc[1:0], bp.upd_ghr, bp.upd_mispredict, bp.fetch_valid};
`endif

    // Capture stage; the BHT index is resolved here so upd_ghr need not be kept.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_upd_vld   <= 1'b0;
            r_upd_br    <= 1'b0;
            r_upd_taken <= 1'b0;
            r_upd_pcw   <= '0;
            r_upd_tgt   <= '0;
            r_upd_idx   <= '0;
        end else begin
            r_upd_vld <= bp.upd_valid;
            if (bp.upd_valid) begin
                r_upd_br    <= bp.upd_is_branch;
                r_upd_taken <= bp.upd_taken;
                r_upd_pcw   <= bp.upd_pc[31:2];
                r_upd_tgt   <= bp.upd_target;
                r_upd_idx   <= w_upd_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            for (int i = 0; i < BHT_N; i++) r_bht[i] <= BHT_RESET;
        end else if (r_upd_vld && r_upd_br) begin
            r_bht[r_upd_idx] <= bht_next(r_bht[r_upd_idx], r_upd_taken);
        end
    end

    btb_array #(.IDX_BITS(BTB_IDX_BITS)) u_btb (
        .clk            (clk),
        .rst_n          (start),
        .i_rd_pcw       (bp.pc_fetch[31:2]),
        .o_hit          (w_hit),
        .o_target       (w_tgt),
        .o_is_branch    (w_is_br),
        .i_we           (r_upd_vld && r_upd_taken),
        .i_wr_pcw       (r_upd_pcw),
        .i_wr_target    (r_upd_tgt),
        .i_wr_is_branch (r_upd_br)
    );

    assign w_ctr_t       = r_bht[w_lk_idx][1];
    assign w_pred        = w_hit && (!w_is_br || w_ctr_t);
    assign bp.pred_taken = w_pred;
    assign bp.pc_pred    = w_pred ? w_tgt : bp.pc_fetch + 32'd4;
    assign bp.pred_ghr   = w_ghr;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; expectations queued at drive time and
// checked at the following falling edge.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.BHT_IDX_BITS(8)) bus ();

    branch_predictor #(.BTB_IDX_BITS(6), .BHT_IDX_BITS(8)) dut (
        .clk   (clk),
        .start (start),
        .bp    (bus)
    );

    typedef struct {
        string       tag;
        logic        tk;
        logic [31:0] pc;
        logic [7:0]  ghr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic upd_set(input logic br, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic mp, input logic [7:0] g);
        bus.upd_valid = 1'b1; bus.upd_is_branch = br; bus.upd_pc = pc;
        bus.upd_taken = tk; bus.upd_target = tgt; bus.upd_mispredict = mp; bus.upd_ghr = g;
    endtask

    task automatic upd_clr();
        bus.upd_valid = 1'b0; bus.upd_mispredict = 1'b0;
    endtask

    // One cycle: drive a lookup, check it at the falling edge, step past the next rising edge.
    task automatic look(input string tag, input logic [31:0] pc, input logic fv,
                        input logic et, input logic [31:0] ep, input logic [7:0] eg);
        exp_t e;
        exp_t o;
        bus.pc_fetch = pc; bus.fetch_valid = fv;
        e.tag = tag; e.tk = et; e.pc = ep; e.ghr = eg;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        chk({o.tag, ".taken"}, 32'(bus.pred_taken), 32'(o.tk));
        chk({o.tag, ".pc"}, bus.pc_pred, o.pc);
        chk({o.tag, ".ghr"}, 32'(bus.pred_ghr), 32'(o.ghr));
        @(posedge clk); #1;
    endtask

    initial begin
        bus.pc_fetch = '0; bus.fetch_valid = 1'b0;
        bus.upd_valid = 1'b0; bus.upd_is_branch = 1'b0; bus.upd_pc = '0;
        bus.upd_taken = 1'b0; bus.upd_target = '0; bus.upd_mispredict = 1'b0; bus.upd_ghr = '0;
        repeat (2) @(posedge clk);
        #1;
        look("rst_hold", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
        start = 1'b1;
        look("rst_look", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 8'h00);

        // JAL: captured at end of N, visible from N+2
        upd_set(1'b0, 32'h200, 1'b1, 32'h340, 1'b0, 8'h00);
        look("jal_n", 32'h200, 1'b0, 1'b0, 32'h204, 8'h00);
        upd_clr();
        look("jal_n1", 32'h200, 1'b0, 1'b0, 32'h204, 8'h00);
        look("jal_n2", 32'h200, 1'b0, 1'b1, 32'h340, 8'h00);

        // Three back-to-back taken updates drive counter 01 -> 11
        upd_set(1'b1, 32'h300, 1'b1, 32'h380, 1'b0, 8'h00);
        look("sat_a0", 32'h300, 1'b0, 1'b0, 32'h304, 8'h00);
        look("sat_a1", 32'h300, 1'b0, 1'b0, 32'h304, 8'h00);
        look("sat_a2", 32'h300, 1'b0, 1'b1, 32'h380, 8'h00);
        upd_set(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 8'h00);
        look("sat_a3", 32'h300, 1'b0, 1'b1, 32'h380, 8'h00);
        upd_clr();
        look("sat_nt1a", 32'h300, 1'b0, 1'b1, 32'h380, 8'h00);
        look("sat_nt1b", 32'h300, 1'b0, 1'b1, 32'h380, 8'h00);
        upd_set(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 8'h00);
        look("sat_nt2a", 32'h300, 1'b0, 1'b1, 32'h380, 8'h00);
        upd_clr();
        look("sat_nt2b", 32'h300, 1'b0, 1'b1, 32'h380, 8'h00);
        look("sat_nt2c", 32'h300, 1'b0, 1'b0, 32'h304, 8'h00);

        // Same BTB index, different tag
        upd_set(1'b0, 32'h000, 1'b1, 32'h080, 1'b0, 8'h00);
        look("alias_a", 32'h000, 1'b0, 1'b0, 32'h004, 8'h00);
        upd_clr();
        look("alias_b", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
        look("alias_own", 32'h000, 1'b0, 1'b1, 32'h080, 8'h00);
        look("alias_oth", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
        look("alias_old", 32'h300, 1'b0, 1'b0, 32'h304, 8'h00);

        // Reset lands between capture and write
        upd_set(1'b0, 32'h400, 1'b1, 32'h500, 1'b0, 8'h00);
        look("mid_cap", 32'h400, 1'b0, 1'b0, 32'h404, 8'h00);
        start = 1'b0;
        upd_clr();
        look("mid_rst", 32'h400, 1'b0, 1'b0, 32'h404, 8'h00);
        start = 1'b1;
        look("mid_rel0", 32'h400, 1'b0, 1'b0, 32'h404, 8'h00);
        look("mid_rel1", 32'h400, 1'b0, 1'b0, 32'h404, 8'h00);
        look("mid_rel2", 32'h000, 1'b0, 1'b0, 32'h004, 8'h00);

        // GHR repair against a simultaneous speculative branch hit
        upd_set(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 8'h00);
        look("g_pre0", 32'h600, 1'b0, 1'b0, 32'h604, 8'h00);
        upd_set(1'b1, 32'h010, 1'b1, 32'h020, 1'b1, 8'h07);
        look("g_pre1", 32'h600, 1'b0, 1'b0, 32'h604, 8'h00);
        upd_set(1'b1, 32'h014, 1'b1, 32'h024, 1'b1, 8'h03);
`ifdef BPU_GSHARE_EN
        look("g_spec", 32'h600, 1'b1, 1'b0, 32'h604, 8'h0F);
        upd_clr();
        look("g_rep", 32'h100, 1'b0, 1'b0, 32'h104, 8'h07);
`else
        look("g_spec", 32'h600, 1'b1, 1'b1, 32'h700, 8'h00);
        upd_clr();
        look("g_rep", 32'h100, 1'b0, 1'b0, 32'h104, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
